// File: rtl/key_pulse_gen_pkg.sv
// Shared key-bus definitions for the menu/game key front end.
// Bit indices, 25 MHz timing defaults and the repeat FSM state type.
package key_pulse_gen_pkg;

  localparam int NUM_KEYS = 6;

  localparam int KEY_DIFF_DN = 0;
  localparam int KEY_DIFF_UP = 1;
  localparam int KEY_LEFT    = 2;
  localparam int KEY_RIGHT   = 3;
  localparam int KEY_START   = 4;
  localparam int KEY_EXIT    = 5;

  // 20 ms, 500 ms and 100 ms at 25 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_PERIOD   = 2500000;

  localparam logic [NUM_KEYS-1:0] DEF_REPEAT_MASK = 6'b001111;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_pulse_gen_ch.sv
// One key channel: 2-flop synchroniser, debounce and auto-repeat FSM.
// Emits a registered one-cycle pulse per accepted press and per repeat.
module key_pulse_ch
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic pixel_clk,
  input  logic sys_rst_n,
  input  logic key_raw_n,
  output logic key,
  output logic key_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW =
    $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST =
    RW'(REPEAT_PERIOD - 1);

  logic          sync1;
  logic          sync_n;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_d;
  logic          held_d;
  logic          key_d;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_d;
  logic          pressed;
  logic          press;
  rpt_state_t    state;
  rpt_state_t    state_d;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1    <= 1'b1;
      sync_n   <= 1'b1;
      cnt      <= '0;
      key_held <= 1'b0;
      key      <= 1'b0;
      state    <= RPT_IDLE;
      rcnt     <= '0;
    end else begin
      sync1    <= key_raw_n;
      sync_n   <= sync1;
      cnt      <= cnt_d;
      key_held <= held_d;
      key      <= key_d;
      state    <= state_d;
      rcnt     <= rcnt_d;
    end
  end

  assign pressed = ~sync_n;

  always_comb begin
    cnt_d  = '0;
    held_d = key_held;
    if (pressed != key_held) begin
      if (cnt == DB_LAST) begin
        held_d = pressed;
      end else begin
        cnt_d = cnt + DW'(1);
      end
    end
  end

  assign press = held_d & ~key_held;

  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    key_d   = press;
    if (REPEAT_EN) begin
      unique case (state)
        RPT_IDLE: begin
          if (press) begin
            state_d = RPT_DELAY;
            rcnt_d  = '0;
          end
        end
        RPT_DELAY: begin
          if (rcnt == RD_LAST) begin
            key_d   = 1'b1;
            rcnt_d  = '0;
            state_d = RPT_REPEAT;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
        RPT_REPEAT: begin
          if (rcnt == RP_LAST) begin
            key_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
      // a release accepted this edge wins over a due repeat
      if (!held_d) begin
        state_d = RPT_IDLE;
        rcnt_d  = '0;
        key_d   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Key interface front end: six debounced, pulse-per-press channels
// driving the menu/game state machine key bus.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic                pixel_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_pulse_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .pixel_clk(pixel_clk),
      .sys_rst_n(sys_rst_n),
      .key_raw_n(key_raw_n[i]),
      .key      (key[i]),
      .key_held (key_held[i])
    );
  end

endmodule
